// File: rtl/pi_link_master.sv
// ---------------------------------------------------------------------------
// pi_link_master
//
// Host-side master of the GPIO byte link to the ISA capture FPGA. It
// generates the link clock and the {STATE1,STATE0} code, drains captured
// ISA-write bytes from the FPGA outbound RAM, and (optionally) pushes 16-bit
// stereo frames into the FPGA S/PDIF FIFOs.
//
// Optional feature macro: PI_LINK_AUDIO_EN
//   defined   -> AUDIO state, frame latch and rx_req synchronizer are built
//   undefined -> fetch-only master; link_di and sample_ready are tied to 0
//
// Parameters:
//   CLK_DIV   clk cycles per link-clock half period (>= 2)
//   IDLE_MIN  state-0 link rises required before each decision (>= 2)
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   link_clock          FPGA CLOCK pin
//   link_state[1:0]     FPGA {STATE1,STATE0}
//   link_di[7:0]        FPGA DI7..DI0 (audio bytes)
//   link_do[7:0]        FPGA DO7..DO0 (captured byte), asynchronous
//   tx_req, rx_req      FPGA request lines, asynchronous
//   rx_data/rx_valid    fetched byte with one-cycle strobe
//   rx_ready            byte consumer can accept
//   sample_l/sample_r   signed PCM frame offered with sample_valid
//   sample_ready        one-cycle frame accept strobe
// ---------------------------------------------------------------------------
module pi_link_master #(
    parameter int CLK_DIV  = 4,
    parameter int IDLE_MIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        link_clock,
    output logic [1:0]  link_state,
    output logic [7:0]  link_di,
    input  logic [7:0]  link_do,
    input  logic        tx_req,
    input  logic        rx_req,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [15:0] sample_l,
    input  logic [15:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready
);

    localparam int PH_W  = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(IDLE_MIN + 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_MIN);

`ifdef PI_LINK_AUDIO_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_AUDIO} state_t;
`else
    typedef enum logic {S_IDLE, S_FETCH} state_t;
`endif

    logic [PH_W-1:0]  phase_q;
    logic             link_clock_q;
    logic             fall_tick;
    logic             rise_tick;
    logic             tx_meta_q;
    logic             tx_sync_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             last_audio_q, last_audio_d;
    logic [1:0]       link_state_q, link_state_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             fetch_ok;
    logic             audio_ok;

    // Link clock generator: the flop toggles when the phase counter wraps.
    // The wrap cycle is a fall tick when the clock is currently high and a
    // rise tick when it is low; all link-side registers update on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= '0;
            link_clock_q <= 1'b0;
        end else if (phase_q == PH_LAST) begin
            phase_q      <= '0;
            link_clock_q <= ~link_clock_q;
        end else begin
            phase_q      <= phase_q + PH_W'(1);
        end
    end

    assign fall_tick = (phase_q == PH_LAST) &&  link_clock_q;
    assign rise_tick = (phase_q == PH_LAST) && !link_clock_q;

    // Two-flop synchronizer for the asynchronous FPGA transmit request.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_meta_q <= 1'b0;
            tx_sync_q <= 1'b0;
        end else begin
            tx_meta_q <= tx_req;
            tx_sync_q <= tx_meta_q;
        end
    end

    assign fetch_ok = tx_sync_q && rx_ready;

`ifdef PI_LINK_AUDIO_EN
    logic        rx_meta_q;
    logic        rx_sync_q;
    logic [23:0] frame_q, frame_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  byte_idx_nxt;
    logic [7:0]  link_di_q, link_di_d;
    logic        sample_ready_q, sample_ready_d;
    logic [7:0]  next_byte;

    // Two-flop synchronizer for the FPGA FIFO-space request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b0;
            rx_sync_q <= 1'b0;
        end else begin
            rx_meta_q <= rx_req;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign audio_ok     = rx_sync_q && sample_valid;
    assign byte_idx_nxt = byte_idx_q + 3'd1;

    // The first byte (R high) goes out directly from the input on the
    // deciding tick, so the latch only keeps L and R low.
    // frame_q = {L[15:8], L[7:0], R[7:0]}; bytes 4 and 5 are zero padding.
    always_comb begin
        case (byte_idx_nxt)
            3'd1:    next_byte = frame_q[7:0];
            3'd2:    next_byte = frame_q[23:16];
            3'd3:    next_byte = frame_q[15:8];
            default: next_byte = 8'h00;
        endcase
    end

    // Audio-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q        <= '0;
            byte_idx_q     <= '0;
            link_di_q      <= '0;
            sample_ready_q <= 1'b0;
        end else begin
            frame_q        <= frame_d;
            byte_idx_q     <= byte_idx_d;
            link_di_q      <= link_di_d;
            sample_ready_q <= sample_ready_d;
        end
    end

    assign link_di      = link_di_q;
    assign sample_ready = sample_ready_q;
`else
    logic unused_audio_inputs;

    assign audio_ok            = 1'b0;
    assign link_di             = 8'h00;
    assign sample_ready        = 1'b0;
    assign unused_audio_inputs = ^{rx_req, sample_valid, sample_l, sample_r};
`endif

    // Control state register. last_audio resets to 1 so that the first
    // contested decision after reset goes to a byte fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idle_cnt_q   <= '0;
            last_audio_q <= 1'b1;
            link_state_q <= 2'd0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            last_audio_q <= last_audio_d;
            link_state_q <= link_state_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
        end
    end

    // Next-state logic. IDLE counts state-0 rises (saturating) so the FPGA
    // has time to refresh TX_REQ and its RAM output before the next decision.
    // Every decision and every state exit happens on a fall tick, which keeps
    // link_state/link_di stable for a full half period before each rise.
    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = idle_cnt_q;
        last_audio_d = last_audio_q;
        link_state_d = link_state_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
`ifdef PI_LINK_AUDIO_EN
        frame_d        = frame_q;
        byte_idx_d     = byte_idx_q;
        link_di_d      = link_di_q;
        sample_ready_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rise_tick && (idle_cnt_q != CNT_MAX)) begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
                if (fall_tick && (idle_cnt_q == CNT_MAX)) begin
                    if (fetch_ok && (!audio_ok || last_audio_q)) begin
                        state_d      = S_FETCH;
                        link_state_d = 2'd1;
                        rx_data_d    = link_do;
                        rx_valid_d   = 1'b1;
                        last_audio_d = 1'b0;
                    end
`ifdef PI_LINK_AUDIO_EN
                    else if (audio_ok) begin
                        state_d        = S_AUDIO;
                        link_state_d   = 2'd3;
                        frame_d        = {sample_l, sample_r[7:0]};
                        link_di_d      = sample_r[15:8];
                        byte_idx_d     = 3'd0;
                        sample_ready_d = 1'b1;
                        last_audio_d   = 1'b1;
                    end
`endif
                end
            end
            S_FETCH: begin
                if (fall_tick) begin
                    state_d      = S_IDLE;
                    link_state_d = 2'd0;
                    idle_cnt_d   = '0;
                end
            end
`ifdef PI_LINK_AUDIO_EN
            S_AUDIO: begin
                if (fall_tick) begin
                    if (byte_idx_q == 3'd5) begin
                        state_d      = S_IDLE;
                        link_state_d = 2'd0;
                        link_di_d    = 8'h00;
                        idle_cnt_d   = '0;
                    end else begin
                        byte_idx_d = byte_idx_nxt;
                        link_di_d  = next_byte;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign link_clock = link_clock_q;
    assign link_state = link_state_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;

endmodule
